// File: rtl/l1_gain_pkg.sv
// Shared definitions for the layer-1 apical gain array: sweep FSM state,
// fixed-point gain constants, default input weights and saturation helpers.
package l1_gain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Q.14 fixed point: 1.0 = 16384
  localparam int ONE      = 16384;
  localparam int HALF     = 8192;
  localparam int GAIN_MAX = 24576;
  // Target drive limit (+/-0.75)
  localparam int TGT_LIM  = 12288;

  // Default input weights (0.2 / 0.3 / 0.2)
  localparam int W_MAT_DEF = 3277;
  localparam int W_FB1_DEF = 4915;
  localparam int W_FB2_DEF = 3277;

  function automatic int sat_int(int x, int lo, int hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Clamp x to the range of a w-bit two's-complement value
  function automatic int sat_width(int x, int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return sat_int(x, lo, hi);
  endfunction

endpackage

// File: rtl/sst_leaky_integ.sv
// One step of a first-order leaky integrator:
//   next = sat(state + ((target - state) >>> SHIFT))
// Purely combinational; the caller owns the state registers.
module sst_leaky_integ
  import l1_gain_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int SHIFT = 7
) (
  input  logic signed [WIDTH-1:0] i_target,
  input  logic signed [WIDTH-1:0] i_state,
  output logic signed [WIDTH-1:0] o_next
);

  // One extra bit so the difference of two full-range samples cannot wrap
  logic signed [WIDTH:0] w_diff;
  logic signed [WIDTH:0] w_step;

  assign w_diff = (WIDTH + 1)'(i_target) - (WIDTH + 1)'(i_state);
  // Arithmetic shift floors toward -inf: falling steps never stall at -0
  assign w_step = w_diff >>> SHIFT;
  assign o_next = WIDTH'(sat_width(int'(i_state) + int'(w_step), WIDTH));

endmodule

// File: rtl/layer1_gain_array.sv
// Layer-1 apical gain array. Each clk_en tick starts a sweep that snapshots
// all inputs, then updates one channel per clock through a single shared
// leaky-integrator datapath. gain = 1.0 + sst, clamped to [0.5, 1.5].
// Optional feature macro: L1_VIP_DISINHIBIT_EN adds a faster per-channel VIP
// state driven by attn_in that contributes half its value to the gain.
module layer1_gain_array
  import l1_gain_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int NCH       = 4,
  parameter int TAU_SHIFT = 7,
  parameter int W_MAT     = W_MAT_DEF,
  parameter int W_FB1     = W_FB1_DEF,
  parameter int W_FB2     = W_FB2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NCH*WIDTH-1:0] matrix_in,
  input  logic [NCH*WIDTH-1:0] fb1_in,
  input  logic [NCH*WIDTH-1:0] fb2_in,
  input  logic [NCH*WIDTH-1:0] attn_in,
  output logic [NCH*WIDTH-1:0] gain_out,
  output logic [NCH*WIDTH-1:0] sst_out,
  output logic [NCH*WIDTH-1:0] vip_out,
  output logic                 sweep_done,
  output logic                 overrun
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int SW   = WIDTH + 2;

  localparam logic signed [WIDTH-1:0] W_MAT_S = WIDTH'(W_MAT);
  localparam logic signed [WIDTH-1:0] W_FB1_S = WIDTH'(W_FB1);
  localparam logic signed [WIDTH-1:0] W_FB2_S = WIDTH'(W_FB2);

  // Full-precision product, rescaled, kept to the sum width
  function automatic logic signed [SW-1:0] wterm(logic signed [WIDTH-1:0] x,
                                                 logic signed [WIDTH-1:0] w);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'(w);
    p = p >>> FRAC;
    return SW'(p);
  endfunction

  state_e                  r_state;
  logic [CH_W-1:0]         r_ch;
  logic                    r_overrun;
  logic [NCH*WIDTH-1:0]    r_snap_mat;
  logic [NCH*WIDTH-1:0]    r_snap_fb1;
  logic [NCH*WIDTH-1:0]    r_snap_fb2;
  logic signed [WIDTH-1:0] r_sst  [NCH];
  logic signed [WIDTH-1:0] r_gain [NCH];

  logic signed [WIDTH-1:0] w_mat_ch, w_fb1_ch, w_fb2_ch;
  logic signed [SW-1:0]    w_sum;
  logic signed [WIDTH-1:0] w_target;
  logic signed [WIDTH-1:0] w_sst_next;
  logic signed [WIDTH-1:0] w_sst_eff;
  logic signed [WIDTH-1:0] w_gain;

  // Select the snapshot of the channel being processed this cycle
  assign w_mat_ch = $signed(r_snap_mat[r_ch*WIDTH +: WIDTH]);
  assign w_fb1_ch = $signed(r_snap_fb1[r_ch*WIDTH +: WIDTH]);
  assign w_fb2_ch = $signed(r_snap_fb2[r_ch*WIDTH +: WIDTH]);

  assign w_sum    = wterm(w_mat_ch, W_MAT_S) + wterm(w_fb1_ch, W_FB1_S)
                  + wterm(w_fb2_ch, W_FB2_S);
  assign w_target = WIDTH'(sat_int(int'(w_sum), -TGT_LIM, TGT_LIM));

  sst_leaky_integ #(
    .WIDTH (WIDTH),
    .SHIFT (TAU_SHIFT)
  ) u_sst (
    .i_target (w_target),
    .i_state  (r_sst[r_ch]),
    .o_next   (w_sst_next)
  );

  // Gain uses the freshly updated state so it lands on the same edge
  assign w_gain = WIDTH'(sat_int(ONE + int'(w_sst_eff), HALF, GAIN_MAX));

  // Sweep sequencer, input snapshot and sticky overrun flag
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_overrun  <= 1'b0;
      r_snap_mat <= '0;
      r_snap_fb1 <= '0;
      r_snap_fb2 <= '0;
    end else begin
      if (clk_en && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: if (clk_en) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_snap_mat <= matrix_in;
          r_snap_fb1 <= fb1_in;
          r_snap_fb2 <= fb2_in;
          r_ch       <= '0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (r_ch == CH_W'(NCH - 1)) r_state <= ST_DONE;
          else                        r_ch    <= r_ch + 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-channel SST and gain write-back, one channel per RUN cycle
  // NOTE: the per-channel state arrays are reset explicitly because gain must
  // come out of reset at exactly 1.0 and the integrators at exactly zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_sst[k]  <= '0;
        r_gain[k] <= WIDTH'(ONE);
      end
    end else if (r_state == ST_RUN) begin
      r_sst[r_ch]  <= w_sst_next;
      r_gain[r_ch] <= w_gain;
    end
  end

`ifdef L1_VIP_DISINHIBIT_EN
  logic [NCH*WIDTH-1:0]    r_snap_attn;
  logic signed [WIDTH-1:0] r_vip [NCH];
  logic signed [WIDTH-1:0] w_attn_ch;
  logic signed [WIDTH-1:0] w_vip_next;

  assign w_attn_ch = $signed(r_snap_attn[r_ch*WIDTH +: WIDTH]);

  // VIP tracks attention four times faster than the SST state
  sst_leaky_integ #(
    .WIDTH (WIDTH),
    .SHIFT (TAU_SHIFT - 2)
  ) u_vip (
    .i_target (w_attn_ch),
    .i_state  (r_vip[r_ch]),
    .o_next   (w_vip_next)
  );

  assign w_sst_eff = WIDTH'(sat_width(int'(w_sst_next) + (int'(w_vip_next) >>> 1), WIDTH));

  // Attention snapshot and per-channel VIP write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_attn <= '0;
      for (int k = 0; k < NCH; k++) r_vip[k] <= '0;
    end else if (r_state == ST_LOAD) begin
      r_snap_attn <= attn_in;
    end else if (r_state == ST_RUN) begin
      r_vip[r_ch] <= w_vip_next;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_vip_out
    assign vip_out[k*WIDTH +: WIDTH] = r_vip[k];
  end
`else
  logic w_unused_attn;

  assign w_unused_attn = ^attn_in;
  assign w_sst_eff     = w_sst_next;
  assign vip_out       = '0;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign gain_out[k*WIDTH +: WIDTH] = r_gain[k];
    assign sst_out[k*WIDTH +: WIDTH]  = r_sst[k];
  end

  assign sweep_done = (r_state == ST_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_layer1_gain_array.sv
// Directed bench for layer1_gain_array: reset, sweep latency and snapshot,
// step response up and down, per-channel clamp, overrun, reset mid-sweep and
// the attention input (checked according to L1_VIP_DISINHIBIT_EN).
module tb_layer1_gain_array;

  localparam int W   = 18;
  localparam int NCH = 4;
  localparam int VW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [VW-1:0] matrix_in, fb1_in, fb2_in, attn_in;
  logic [VW-1:0] gain_out, sst_out, vip_out;
  logic          sweep_done, overrun;

  int total = 0;
  int bad   = 0;
  int pulses;

  layer1_gain_array dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .matrix_in  (matrix_in),
    .fb1_in     (fb1_in),
    .fb2_in     (fb2_in),
    .attn_in    (attn_in),
    .gain_out   (gain_out),
    .sst_out    (sst_out),
    .vip_out    (vip_out),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] put(logic [VW-1:0] v, int k, int val);
    v[k*W +: W] = W'(val);
    return v;
  endfunction

  function automatic int get(logic [VW-1:0] v, int k);
    logic signed [W-1:0] s;
    s = v[k*W +: W];
    return int'(s);
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(string tag, int obs, int lo, int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  // One clk_en pulse and an 8-cycle window; called and returns just after a negedge
  task automatic tick(output int p);
    p = 0;
    clk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sweep_done) p++;
      clk_en = 1'b0;
    end
  endtask

  task automatic ticks(int n, output int p);
    int t;
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick(t);
      p += t;
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0;
    matrix_in = '0; fb1_in = '0; fb2_in = '0; attn_in = '0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("rst_gain%0d", k), get(gain_out, k), 16384);
      chk($sformatf("rst_sst%0d", k), get(sst_out, k), 0);
      chk($sformatf("rst_vip%0d", k), get(vip_out, k), 0);
    end
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero inputs: gains stay at 1.0, one sweep_done per tick
    ticks(200, pulses);
    chk("zero_pulses", pulses, 200);
    for (int k = 0; k < NCH; k++) chk($sformatf("zero_gain%0d", k), get(gain_out, k), 16384);
    chk("zero_overrun", int'(overrun), 0);

    // First step tick, walked cycle by cycle: latency and input snapshot
    fb1_in = put(fb1_in, 0, 16384);
    clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;                 // LOAD
    @(negedge clk);                                // RUN ch0 pending
    chk("lat_ch0_before", get(gain_out, 0), 16384);
    fb1_in = put(fb1_in, 1, 16384);                // after snapshot: ignored
    @(negedge clk);
    chk("lat_ch0_gain", get(gain_out, 0), 16422);  // target 4915, 4915>>>7 = 38
    chk("lat_ch0_sst", get(sst_out, 0), 38);
    @(negedge clk);
    @(negedge clk);
    chk("lat_done_early", int'(sweep_done), 0);
    @(negedge clk);
    chk("lat_done_pulse", int'(sweep_done), 1);
    @(negedge clk);
    chk("lat_done_one_cycle", int'(sweep_done), 0);
    chk("snap_ch1_unchanged", get(gain_out, 1), 16384);
    @(negedge clk);
    fb1_in = put(fb1_in, 1, 0);

    // Rising step response on ch0
    ticks(4, pulses);
    chk_rng("step5_gain0", get(gain_out, 0), 16385, 17999);
    ticks(123, pulses);
    chk_rng("step128_gain0", get(gain_out, 0), 18000, 21000);
    ticks(672, pulses);
    chk_rng("step800_gain0", get(gain_out, 0), 21171, 21299);
    chk_rng("step800_sst0", get(sst_out, 0), 4788, 4915);
    for (int k = 1; k < NCH; k++) chk($sformatf("step_other_gain%0d", k), get(gain_out, k), 16384);

    // Step removed: exact return to 1.0
    fb1_in = '0;
    ticks(5, pulses);
    chk_rng("fall5_gain0", get(gain_out, 0), 18001, 21299);
    ticks(1495, pulses);
    chk("fall1500_gain0", get(gain_out, 0), 16384);
    chk("fall1500_sst0", get(sst_out, 0), 0);

    // Per-channel clamp: ch1 driven high, ch2 driven low
    matrix_in = put(put('0, 1, 32768), 2, -32768);
    fb1_in    = matrix_in;
    fb2_in    = matrix_in;
    ticks(800, pulses);
    chk("clamp_hi_gain1", get(gain_out, 1), 24576);
    chk("clamp_lo_gain2", get(gain_out, 2), 8192);
    chk("clamp_gain0", get(gain_out, 0), 16384);
    chk("clamp_gain3", get(gain_out, 3), 16384);
    chk("pre_overrun", int'(overrun), 0);

    // clk_en every 3 cycles: overrun sets and sticks
    for (int i = 0; i < 12; i++) begin
      clk_en = (i % 3 == 0);
      @(negedge clk);
    end
    clk_en = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    repeat (10) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of RUN, then no late updates after release
    clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gain1", get(gain_out, 1), 16384);
    chk("midrst_gain2", get(gain_out, 2), 8192 + 8192);
    chk("midrst_overrun", int'(overrun), 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sweep_done) pulses++;
    end
    chk("postrst_pulses", pulses, 0);
    chk("postrst_gain1", get(gain_out, 1), 16384);
    chk("postrst_gain2", get(gain_out, 2), 16384);
    chk("postrst_sst1", get(sst_out, 1), 0);

    // Attention input only
    matrix_in = '0; fb1_in = '0; fb2_in = '0;
    attn_in   = put('0, 0, 16384);
    ticks(32, pulses);
`ifdef L1_VIP_DISINHIBIT_EN
    chk_rng("vip32_vip0", get(vip_out, 0), 9500, 11000);
    chk("vip32_sst0", get(sst_out, 0), 0);
    chk_rng("vip32_gain0", get(gain_out, 0), 16384 + 4750, 16384 + 5500);
    chk("vip32_vip1", get(vip_out, 1), 0);
`else
    chk("novip_vip0", get(vip_out, 0), 0);
    chk("novip_gain0", get(gain_out, 0), 16384);
    chk("novip_sst0", get(sst_out, 0), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
